axi4_lite_manager: RTL and testbench
====================================

# axi4_lite_manager

Single-outstanding AXI4-Lite manager that converts a simple valid/ready request/response port into AXI4-Lite read and write transactions on an `axi4_lite_if.m` modport. It lets local controllers (testbench sequencers, DMA-style loaders, boot sequencers) drive the Ascon core's AXI4-Lite register subordinate. One AXI transaction is in flight at any time, and responses are returned in request order.

## Interface
- `ADDRESS_WIDTH`, 32, AXI address width; must match the connected interface.
- `DATA_WIDTH`, 32, AXI data width; `STRB_WIDTH = DATA_WIDTH/8`.
- `PROT`, 3'b000, constant driven on `awprot`/`arprot`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRESS_WIDTH  target address.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `req_wstrb`  in  STRB_WIDTH  write strobes; ignored for reads.
- `resp_valid`  out  1  response present; held until `resp_ready`.
- `resp_ready`  in  1  response consumed when `resp_valid & resp_ready`.
- `resp_write`  out  1  echoes `req_write` of the completed request.
- `resp_rdata`  out  DATA_WIDTH  `rdata` for reads; 0 for writes.
- `resp_code`  out  2  captured `rresp`/`bresp`.
- `axi`  interface  `axi4_lite_if.m`  AXI4-Lite manager port.

## Operation
- FSM states: IDLE, WR (AW and W pending), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: on request acceptance, register addr/data/strb/write and go to WR or RD_ADDR.
- WR: assert `awvalid` and `wvalid` together.
  - Track `aw_done` and `w_done` independently; each valid drops on its own handshake.
  - Either order is accepted, and both may complete in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp` and go to RESP.
- RD_ADDR: `arvalid`=1 until `arready`, then go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata`/`rresp` and go to RESP.
- RESP: `resp_valid`=1. On `resp_ready`, go to IDLE, or start the buffered request (see Configuration).
- AXI rules enforced:
  - Once asserted, a valid stays high with stable payload until its handshake completes.
  - Valids never depend combinationally on any ready.
  - `bready`/`rready` are asserted only in their response states.
- `resp_code` passes SLVERR/DECERR through unchanged. The manager takes no retry action.
- Reset values:
  - All AXI valids, `bready`, `rready` = 0.
  - `awaddr`/`araddr`/`wdata` = 0; `wstrb` = 0.
  - `resp_valid` = 0; `resp_*` payload = 0.
  - State = IDLE, so `req_ready` = 1 once `rst_n` is high.
- Reset asserted mid-transaction: abandon immediately and return to reset values. Restoring the subordinate is the system's responsibility.

## Timing
- Request accepted in cycle T: AXI valid(s) are high in T+1 (registered outputs).
- Zero-wait write (AW/W ready and `bvalid` as early as possible): `bvalid` handshake at T+2, `resp_valid` at T+3.
- Zero-wait read: AR handshake at T+1, R handshake at T+2, `resp_valid` at T+3.
- `resp_ready` held high in RESP: the response handshakes in that cycle. Without the buffer, `req_ready` returns to 1 the next cycle.
- Without the configuration macro: `req_ready` = (state == IDLE), so the minimum issue interval is 4 cycles.

## Configuration
- Macro: `AXI4_LITE_MANAGER_REQ_BUF_EN`.
- Defined: adds a one-entry request buffer.
  - `req_ready` = buffer empty, in any state.
  - In IDLE, an incoming request bypasses the buffer.
  - In other states, it is stored in the buffer.
  - On the RESP handshake with the buffer full, go directly to WR/RD_ADDR using the buffered request. Valids rise the next cycle and the buffer frees in that same cycle.
  - A request arriving in the same cycle the buffer drains is accepted only if the buffer is empty at the start of the cycle.
  - Response order equals request order.
- Undefined: no buffer; behaviour exactly as in Timing.

## Test plan
- Reset check: hold `rst_n`=0, then release → all valids/readies 0, `resp_valid`=0, `req_ready`=1.
- Write `addr`=0x10, `wdata`=0xDEADBEEF, `wstrb`=4'hF, with the subordinate accepting W two cycles before AW → exactly one AW and one W handshake with the correct payload; `resp_write`=1, `resp_code`=0, `resp_rdata`=0.
- Read `addr`=0x24 with `arready` delayed 3 cycles and `rdata`=0x12345678, `rresp`=2'b10 → `arvalid` stable for 4 cycles, then `resp_rdata`=0x12345678, `resp_code`=2'b10.
- `resp_ready`=0 for 5 cycles → `resp_valid` and payload stable; no new AXI activity, and `req_ready`=0 (unbuffered build).
- Assert `rst_n`=0 while in WR_RESP → next cycle all outputs at reset values; a new read then completes normally.
- With `AXI4_LITE_MANAGER_REQ_BUF_EN`: write, then a read presented one cycle later → read accepted while the write is in flight; `arvalid` rises the cycle after the write's RESP handshake; responses arrive in order write, then read.

Source files
------------

// File: rtl/axi4_lite_manager_if.sv
// AXI4-Lite bus bundle shared by the manager and any subordinate.
// Modport m is the manager side, modport s the subordinate side.
`timescale 1ns/1ps
interface axi4_lite_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     awvalid;
    logic                     awready;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [STRB_WIDTH-1:0]    wstrb;
    logic                     wvalid;
    logic                     wready;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     arvalid;
    logic                     arready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rvalid;
    logic                     rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_manager.sv
// Single-outstanding AXI4-Lite manager: turns a valid/ready request port into
// AXI4-Lite reads and writes, returning responses in request order.
// Optional macro AXI4_LITE_MANAGER_REQ_BUF_EN adds a one-entry request buffer
// so a new request can be accepted while a transaction is in flight.
`timescale 1ns/1ps
module axi4_lite_manager #(
    parameter int         ADDRESS_WIDTH = 32,
    parameter int         DATA_WIDTH    = 32,
    parameter logic [2:0] PROT          = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_write,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic [1:0]                resp_code,
    axi4_lite_if.m                    axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     arvalid_q, arvalid_d;
    logic                     resp_write_q, resp_write_d;
    logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
    logic [1:0]               resp_code_q, resp_code_d;

    // Request that starts a new AXI transaction this cycle (direct or buffered)
    logic                     launch;
    logic                     launch_write;
    logic [ADDRESS_WIDTH-1:0] launch_addr;
    logic [DATA_WIDTH-1:0]    launch_wdata;
    logic [STRB_WIDTH-1:0]    launch_wstrb;

`ifdef AXI4_LITE_MANAGER_REQ_BUF_EN
    logic                     buf_valid_q, buf_valid_d;
    logic                     buf_write_q, buf_write_d;
    logic [ADDRESS_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0]    buf_wdata_q, buf_wdata_d;
    logic [STRB_WIDTH-1:0]    buf_wstrb_q, buf_wstrb_d;
    logic                     req_fire;

    // Launch from the buffer when it holds a request and the FSM is free; otherwise bypass from IDLE
    always_comb begin
        req_ready    = !buf_valid_q;
        req_fire     = req_valid && !buf_valid_q;
        launch       = 1'b0;
        launch_write = req_write;
        launch_addr  = req_addr;
        launch_wdata = req_wdata;
        launch_wstrb = req_wstrb;
        buf_valid_d  = buf_valid_q;
        buf_write_d  = buf_write_q;
        buf_addr_d   = buf_addr_q;
        buf_wdata_d  = buf_wdata_q;
        buf_wstrb_d  = buf_wstrb_q;
        if (buf_valid_q && (state_q == IDLE || (state_q == RESP && resp_ready))) begin
            launch       = 1'b1;
            launch_write = buf_write_q;
            launch_addr  = buf_addr_q;
            launch_wdata = buf_wdata_q;
            launch_wstrb = buf_wstrb_q;
            buf_valid_d  = 1'b0;
        end else if (req_fire && state_q == IDLE) begin
            launch = 1'b1;
        end
        // A request arriving while busy parks in the (necessarily empty) buffer
        if (req_fire && state_q != IDLE) begin
            buf_valid_d = 1'b1;
            buf_write_d = req_write;
            buf_addr_d  = req_addr;
            buf_wdata_d = req_wdata;
            buf_wstrb_d = req_wstrb;
        end
    end

    // Buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_write_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_wstrb_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_write_q <= buf_write_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_wstrb_q <= buf_wstrb_d;
        end
    end
`else
    // Without a buffer, requests are only taken while idle
    always_comb begin
        req_ready    = (state_q == IDLE);
        launch       = req_valid && (state_q == IDLE);
        launch_write = req_write;
        launch_addr  = req_addr;
        launch_wdata = req_wdata;
        launch_wstrb = req_wstrb;
    end
`endif

    // Next-state and registered-output logic for the transaction FSM
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        resp_write_d = resp_write_q;
        resp_rdata_d = resp_rdata_q;
        resp_code_d  = resp_code_q;
        case (state_q)
            IDLE: begin
            end
            WR: begin
                // AW and W complete independently, in either order or together
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    resp_write_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_code_d  = axi.bresp;
                    state_d      = RESP;
                end
            end
            RD_ADDR: begin
                arvalid_d = arvalid_q && !axi.arready;
                if (!arvalid_d) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    resp_write_d = 1'b0;
                    resp_rdata_d = axi.rdata;
                    resp_code_d  = axi.rresp;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A launch only happens in IDLE or on the RESP handshake, so it overrides the above
        if (launch) begin
            state_d   = launch_write ? WR : RD_ADDR;
            addr_d    = launch_addr;
            awvalid_d = launch_write;
            wvalid_d  = launch_write;
            arvalid_d = !launch_write;
            if (launch_write) begin
                wdata_d = launch_wdata;
                wstrb_d = launch_wstrb;
            end
        end
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == WR_RESP);
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == RD_DATA);

    assign resp_valid  = (state_q == RESP);
    assign resp_write  = resp_write_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_code   = resp_code_q;
endmodule

// File: tb/tb_axi4_lite_manager.sv
// Testbench for axi4_lite_manager: table of transactions against a delay-configurable
// AXI4-Lite subordinate model, a response scoreboard, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_axi4_lite_manager;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;

    always #5 clk = ~clk;

    axi4_lite_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

    axi4_lite_manager #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .resp_code  (resp_code),
        .axi        (axi_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected responses, in request order
    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  code;
    } resp_t;
    resp_t sb[$];
    logic  resp_rdy_en = 1'b1;

    // Subordinate configuration and observation
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] sub_rdata = '0;
    logic [1:0]  sub_resp = '0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, ar_hi = 0;
    logic [31:0] rec_awaddr = '0, rec_wdata = '0, rec_araddr = '0;
    logic [3:0]  rec_wstrb = '0;
    logic        ar_unstable = 1'b0;

    // Subordinate model: decides readies/valids at negedge for the following posedge
    initial begin
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        logic aw_got = 0, w_got = 0, b_done = 0, ar_got = 0, r_done = 0, ar_prev = 0;
        logic [31:0] ar_last = '0;
        axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.arready = 0;
        axi_bus.bvalid = 0; axi_bus.bresp = 0;
        axi_bus.rvalid = 0; axi_bus.rresp = 0; axi_bus.rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.arready = 0;
                axi_bus.bvalid = 0; axi_bus.rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_done = 0; ar_got = 0; r_done = 0; ar_prev = 0;
            end else begin
                if (b_done) begin
                    axi_bus.bvalid = 0; b_done = 0;
                end else if (!axi_bus.bvalid && aw_got && w_got) begin
                    if (b_cnt >= b_dly) begin
                        axi_bus.bvalid = 1; axi_bus.bresp = sub_resp;
                        aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (axi_bus.bvalid && axi_bus.bready) begin b_done = 1; n_b++; end

                if (r_done) begin
                    axi_bus.rvalid = 0; r_done = 0;
                end else if (!axi_bus.rvalid && ar_got) begin
                    if (r_cnt >= r_dly) begin
                        axi_bus.rvalid = 1; axi_bus.rdata = sub_rdata; axi_bus.rresp = sub_resp;
                        ar_got = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                if (axi_bus.rvalid && axi_bus.rready) begin r_done = 1; n_r++; end

                if (axi_bus.awready) axi_bus.awready = 0;
                else if (axi_bus.awvalid) begin
                    if (aw_cnt >= aw_dly) begin
                        axi_bus.awready = 1; aw_got = 1; aw_cnt = 0;
                        rec_awaddr = axi_bus.awaddr; n_aw++;
                    end else aw_cnt++;
                end

                if (axi_bus.wready) axi_bus.wready = 0;
                else if (axi_bus.wvalid) begin
                    if (w_cnt >= w_dly) begin
                        axi_bus.wready = 1; w_got = 1; w_cnt = 0;
                        rec_wdata = axi_bus.wdata; rec_wstrb = axi_bus.wstrb; n_w++;
                    end else w_cnt++;
                end

                if (axi_bus.arvalid) begin
                    ar_hi++;
                    if (ar_prev && axi_bus.araddr != ar_last) ar_unstable = 1;
                    ar_last = axi_bus.araddr;
                end
                ar_prev = axi_bus.arvalid;
                if (axi_bus.arready) axi_bus.arready = 0;
                else if (axi_bus.arvalid) begin
                    if (ar_cnt >= ar_dly) begin
                        axi_bus.arready = 1; ar_got = 1; ar_cnt = 0;
                        rec_araddr = axi_bus.araddr; n_ar++;
                    end else ar_cnt++;
                end
            end
        end
    end

    // Response collector: drives resp_ready and compares each handshake with the scoreboard
    initial begin
        resp_t e;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            resp_ready = resp_rdy_en;
            if (rst_n && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got write=%0d rdata=0x%0h required none", resp_write, resp_rdata);
                end else begin
                    e = sb.pop_front();
                    check("resp_write", {31'd0, resp_write}, {31'd0, e.w});
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_code", {30'd0, resp_code}, {30'd0, e.code});
                end
            end
        end
    end

    // Present a request (caller is at a negedge), wait for acceptance, queue its expected response
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic [1:0] ec);
        int n = 0;
        resp_t e;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        check("req_accept", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            e.w = w; e.rdata = er; e.code = ec;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("drain", {31'd0, sb.size() == 0}, 32'd1);
        @(negedge clk);
    endtask

    task automatic set_delays(input int awd, input int wd, input int bd, input int ard, input int rd);
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          awd, wd, bd, ard, rd;
        logic [31:0] srdata;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_code;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[6];
        int   n0_aw, n0_w, n0_ar, n0_arhi, n;

        vecs[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 2, 0, 0, 0, 0, 32'h0,        2'b00, 32'h0,        2'b00};
        vecs[1] = '{1'b0, 32'h24,       32'h0,        4'h0, 0, 0, 0, 3, 0, 32'h12345678, 2'b10, 32'h12345678, 2'b10};
        vecs[2] = '{1'b1, 32'h3C,       32'hCAFEF00D, 4'h3, 0, 2, 1, 0, 0, 32'h0,        2'b10, 32'h0,        2'b10};
        vecs[3] = '{1'b1, 32'h00,       32'hA5A5A5A5, 4'h9, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 2'b11, 32'h0,        2'b11};
        vecs[4] = '{1'b0, 32'h80,       32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0BADF00D, 2'b11, 32'h0BADF00D, 2'b11};
        vecs[5] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 0, 0, 1, 2, 32'h80000001, 2'b00, 32'h80000001, 2'b00};

        rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) @(negedge clk);
        check("rst_awvalid", {31'd0, axi_bus.awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, axi_bus.wvalid}, 32'd0);
        check("rst_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
        check("rst_bready", {31'd0, axi_bus.bready}, 32'd0);
        check("rst_rready", {31'd0, axi_bus.rready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_awaddr", axi_bus.awaddr, 32'd0);
        check("rst_wdata", axi_bus.wdata, 32'd0);
        check("rst_wstrb", {28'd0, axi_bus.wstrb}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            set_delays(vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].ard, vecs[i].rd);
            sub_rdata = vecs[i].srdata; sub_resp = vecs[i].sresp;
            n0_aw = n_aw; n0_w = n_w; n0_ar = n_ar; n0_arhi = ar_hi;
            send(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_rdata, vecs[i].exp_code);
            wait_drain();
            if (vecs[i].w) begin
                check("aw_count", n_aw - n0_aw, 32'd1);
                check("w_count", n_w - n0_w, 32'd1);
                check("awaddr", rec_awaddr, vecs[i].addr);
                check("wdata", rec_wdata, vecs[i].wdata);
                check("wstrb", {28'd0, rec_wstrb}, {28'd0, vecs[i].strb});
            end else begin
                check("ar_count", n_ar - n0_ar, 32'd1);
                check("aw_count_rd", n_aw - n0_aw, 32'd0);
                check("araddr", rec_araddr, vecs[i].addr);
                check("arvalid_cycles", ar_hi - n0_arhi, vecs[i].ard + 1);
                check("araddr_stable", {31'd0, ar_unstable}, 32'd0);
            end
        end

        // Zero-wait write cycle timing
        set_delays(0, 0, 0, 0, 0); sub_resp = 2'b00;
        req_valid = 1; req_write = 1; req_addr = 32'h48; req_wdata = 32'h0F0F0F0F; req_wstrb = 4'hF;
        check("t_wr_req_ready", {31'd0, req_ready}, 32'd1);
        sb.push_back('{1'b1, 32'h0, 2'b00});
        @(negedge clk); req_valid = 0;
        check("t_wr_awvalid_T1", {31'd0, axi_bus.awvalid}, 32'd1);
        check("t_wr_wvalid_T1", {31'd0, axi_bus.wvalid}, 32'd1);
`ifndef AXI4_LITE_MANAGER_REQ_BUF_EN
        check("t_wr_req_ready_T1", {31'd0, req_ready}, 32'd0);
`endif
        @(negedge clk);
        check("t_wr_bready_T2", {31'd0, axi_bus.bready}, 32'd1);
        check("t_wr_awvalid_T2", {31'd0, axi_bus.awvalid}, 32'd0);
        @(negedge clk);
        check("t_wr_resp_valid_T3", {31'd0, resp_valid}, 32'd1);
        wait_drain();

        // Zero-wait read cycle timing
        sub_rdata = 32'h600DCAFE;
        req_valid = 1; req_write = 0; req_addr = 32'h4C;
        check("t_rd_req_ready", {31'd0, req_ready}, 32'd1);
        sb.push_back('{1'b0, 32'h600DCAFE, 2'b00});
        @(negedge clk); req_valid = 0;
        check("t_rd_arvalid_T1", {31'd0, axi_bus.arvalid}, 32'd1);
        @(negedge clk);
        check("t_rd_rready_T2", {31'd0, axi_bus.rready}, 32'd1);
        check("t_rd_arvalid_T2", {31'd0, axi_bus.arvalid}, 32'd0);
        @(negedge clk);
        check("t_rd_resp_valid_T3", {31'd0, resp_valid}, 32'd1);
        wait_drain();

        // Response back-pressure: everything holds while resp_ready is low
        resp_rdy_en = 1'b0;
        sub_rdata = 32'h55AA55AA; sub_resp = 2'b01;
        send(1'b0, 32'h44, 32'h0, 4'h0, 32'h55AA55AA, 2'b01);
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_resp_rdata", resp_rdata, 32'h55AA55AA);
            check("stall_resp_code", {30'd0, resp_code}, 32'd1);
            check("stall_arvalid", {31'd0, axi_bus.arvalid}, 32'd0);
            check("stall_awvalid", {31'd0, axi_bus.awvalid}, 32'd0);
            check("stall_rready", {31'd0, axi_bus.rready}, 32'd0);
`ifndef AXI4_LITE_MANAGER_REQ_BUF_EN
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
`endif
            @(negedge clk);
        end
        resp_rdy_en = 1'b1;
        wait_drain();

        // Reset while waiting for the write response
        set_delays(0, 0, 8, 0, 0); sub_resp = 2'b00;
        req_valid = 1; req_write = 1; req_addr = 32'h70; req_wdata = 32'h11223344; req_wstrb = 4'hF;
        @(negedge clk); req_valid = 0;
        n = 0;
        while (!axi_bus.bready && n < 50) begin @(negedge clk); n++; end
        check("reach_wr_resp", {31'd0, axi_bus.bready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bready", {31'd0, axi_bus.bready}, 32'd0);
        check("mid_rst_awaddr", axi_bus.awaddr, 32'd0);
        check("mid_rst_wdata", axi_bus.wdata, 32'd0);
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_delays(0, 0, 0, 1, 1);
        sub_rdata = 32'hFEEDFACE; sub_resp = 2'b00;
        n0_ar = n_ar;
        send(1'b0, 32'h74, 32'h0, 4'h0, 32'hFEEDFACE, 2'b00);
        wait_drain();
        check("post_rst_ar_count", n_ar - n0_ar, 32'd1);
        check("post_rst_araddr", rec_araddr, 32'h74);

`ifdef AXI4_LITE_MANAGER_REQ_BUF_EN
        // Buffered: a read presented one cycle after a write is accepted during the write
        set_delays(0, 0, 0, 0, 0);
        sub_rdata = 32'h0A0B0C0D; sub_resp = 2'b00;
        send(1'b1, 32'h100, 32'h99887766, 4'hF, 32'h0, 2'b00);
        check("buf_write_in_flight", {31'd0, axi_bus.awvalid}, 32'd1);
        send(1'b0, 32'h104, 32'h0, 4'h0, 32'h0A0B0C0D, 2'b00);
        check("buf_full_req_ready", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!(resp_valid && resp_ready) && n < 50) begin @(negedge clk); n++; end
        check("buf_first_resp_write", {31'd0, resp_write}, 32'd1);
        @(negedge clk);
        check("buf_arvalid_after_resp", {31'd0, axi_bus.arvalid}, 32'd1);
        check("buf_freed_req_ready", {31'd0, req_ready}, 32'd1);
        wait_drain();
        check("buf_araddr", rec_araddr, 32'h104);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
